// File: rtl/puf_key_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : puf_key_sequencer_if
//  Purpose  : Bundles the host key-request handshake and the PUF control /
//             sample signals of the PUF key sequencer.
//  Revision : 1.0  initial release
// ============================================================================
interface puf_key_sequencer_if #(
  parameter int TOT_CNT_BITS   = 32,
  parameter int CHALLENGE_BITS = 4,
  parameter int KEY_BITS       = 64
);
  // Host side
  logic                      gen_start;
  logic [CHALLENGE_BITS-1:0] chal_first;
  logic [CHALLENGE_BITS-1:0] chal_last;
  logic                      busy;
  logic [KEY_BITS-1:0]       key;
  logic                      key_valid;
  logic                      key_ready;
  logic                      error;
  // PUF side
  logic                      start_puf;
  logic [CHALLENGE_BITS-1:0] challenge;
  logic [TOT_CNT_BITS-1:0]   puf_response;
  logic                      store_response_puf;
  logic                      puf_done;

  // Sequencer view
  modport slave (
    input  gen_start, chal_first, chal_last, key_ready,
           puf_response, store_response_puf, puf_done,
    output busy, key, key_valid, error, start_puf, challenge
  );

  // Environment view (host and PUF together)
  modport master (
    output gen_start, chal_first, chal_last, key_ready,
           puf_response, store_response_puf, puf_done,
    input  busy, key, key_valid, error, start_puf, challenge
  );
endinterface
`default_nettype wire

// File: rtl/puf_key_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : puf_key_sequencer
//  Purpose  : Walks the PUF over a challenge range, pairs stored counter
//             samples into response bits (A > B -> 1), collects KEY_BITS bits
//             and offers the key to the host over a valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module puf_key_sequencer #(
  parameter int TOT_CNT_BITS   = 32,
  parameter int CHALLENGE_BITS = 4,
  parameter int KEY_BITS       = 64,
  parameter int TIMEOUT_BITS   = 24
) (
  input wire              clk,
  input wire              reset,
  puf_key_sequencer_if.slave bus
);

  localparam int c_IDX_W = (KEY_BITS > 1) ? $clog2(KEY_BITS) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(KEY_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_RUN    = 3'd2,
    S_DRAIN  = 3'd3,
    S_NEXT   = 3'd4,
    S_OUTPUT = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  state_t                    r_state;
  logic [CHALLENGE_BITS-1:0] r_cur_chal;
  logic [CHALLENGE_BITS-1:0] r_chal_last;
  logic [TOT_CNT_BITS-1:0]   r_samp_a;
  logic                      r_have_a;
  logic [c_IDX_W-1:0]        r_bit_idx;
  logic [KEY_BITS-1:0]       r_key;
  logic [TIMEOUT_BITS-1:0]   r_timer;
  logic                      r_busy;
  logic                      r_start_puf;
  logic                      r_key_valid;
  logic                      r_error;

  logic [TIMEOUT_BITS-1:0]   w_timer_next;
  logic                      w_timeout;
  logic                      w_fill;

  // Watchdog fires on the cycle the timer would become all-ones; a store that
  // completes the second sample of the last pair fills the key.
  always_comb begin
    w_timer_next = r_timer + 1'b1;
    w_timeout    = &w_timer_next;
    w_fill       = bus.store_response_puf && r_have_a && (r_bit_idx == c_LAST_IDX);
  end

  // Sequencer FSM; outputs are registered and updated together with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cur_chal  <= '0;
      r_chal_last <= '0;
      r_samp_a    <= '0;
      r_have_a    <= 1'b0;
      r_bit_idx   <= '0;
      r_key       <= '0;
      r_timer     <= '0;
      r_busy      <= 1'b0;
      r_start_puf <= 1'b0;
      r_key_valid <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_start_puf <= 1'b0;
      case (r_state)
        S_IDLE, S_ERROR: begin
          if (bus.gen_start) begin
            r_chal_last <= bus.chal_last;
            r_key       <= '0;
            r_bit_idx   <= '0;
            r_have_a    <= 1'b0;
            r_error     <= 1'b0;
            if (bus.chal_last < bus.chal_first) begin
              // Empty range: fault without ever launching the PUF.
              r_state <= S_ERROR;
              r_error <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_cur_chal  <= bus.chal_first;
              r_state     <= S_LAUNCH;
              r_start_puf <= 1'b1;
              r_busy      <= 1'b1;
            end
          end
        end

        S_LAUNCH: begin
          r_timer  <= '0;
          r_have_a <= 1'b0;
          r_state  <= S_RUN;
        end

        S_RUN: begin
          r_timer <= w_timer_next;
          if (bus.store_response_puf) begin
            if (!r_have_a) begin
              r_samp_a <= bus.puf_response;
              r_have_a <= 1'b1;
            end else begin
              r_key[r_bit_idx] <= (r_samp_a > bus.puf_response);
              r_bit_idx        <= r_bit_idx + 1'b1;
              r_have_a         <= 1'b0;
            end
          end
          // The store above is resolved before done is considered.
          if (w_fill) begin
            if (bus.puf_done) begin
              r_state     <= S_OUTPUT;
              r_busy      <= 1'b0;
              r_key_valid <= 1'b1;
            end else begin
              r_state <= S_DRAIN;
            end
          end else if (bus.puf_done) begin
            // Any unpaired sample of this run is dropped.
            r_have_a <= 1'b0;
            if (r_cur_chal == r_chal_last) begin
              r_state <= S_ERROR;
              r_error <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_NEXT;
            end
          end else if (w_timeout) begin
            r_state <= S_ERROR;
            r_error <= 1'b1;
            r_busy  <= 1'b0;
          end
        end

        S_DRAIN: begin
          // Key is full; let the PUF finish so it is idle before any relaunch.
          r_timer <= w_timer_next;
          if (bus.puf_done) begin
            r_state     <= S_OUTPUT;
            r_busy      <= 1'b0;
            r_key_valid <= 1'b1;
          end else if (w_timeout) begin
            r_state <= S_ERROR;
            r_error <= 1'b1;
            r_busy  <= 1'b0;
          end
        end

        S_NEXT: begin
          // cur_chal < chal_last here, so the increment cannot wrap.
          r_cur_chal  <= r_cur_chal + 1'b1;
          r_state     <= S_LAUNCH;
          r_start_puf <= 1'b1;
        end

        S_OUTPUT: begin
          if (bus.key_ready) begin
            r_key_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.key       = r_key;
  assign bus.key_valid = r_key_valid;
  assign bus.error     = r_error;
  assign bus.start_puf = r_start_puf;
  assign bus.challenge = r_cur_chal;

endmodule
`default_nettype wire

// File: tb/tb_puf_key_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_puf_key_sequencer
//  Purpose  : Self-checking bench for puf_key_sequencer (KEY_BITS=4,
//             TIMEOUT_BITS=4). Expected launches, keys and faults are queued
//             by the stimulus and retired by a monitor on the falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_puf_key_sequencer;

  localparam int c_TOT = 32;
  localparam int c_CB  = 4;
  localparam int c_KB  = 4;
  localparam int c_TB  = 4;

  localparam logic [1:0] c_EV_LAUNCH = 2'd0;
  localparam logic [1:0] c_EV_KEY    = 2'd1;
  localparam logic [1:0] c_EV_ERR    = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] val;
  } ev_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  ev_t  exp_q[$];
  logic prev_err;

  puf_key_sequencer_if #(.TOT_CNT_BITS(c_TOT), .CHALLENGE_BITS(c_CB), .KEY_BITS(c_KB)) bus ();

  puf_key_sequencer #(
    .TOT_CNT_BITS  (c_TOT),
    .CHALLENGE_BITS(c_CB),
    .KEY_BITS      (c_KB),
    .TIMEOUT_BITS  (c_TB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] kind, input logic [31:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  // Retire one observed DUT event against the head of the scoreboard.
  task automatic got(input logic [1:0] kind, input logic [31:0] val);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event actual=kind%0d/%0h required=none", kind, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== kind || e.val !== val) begin
        failures++;
        $display("FAIL event actual=kind%0d/%0h required=kind%0d/%0h", kind, val, e.kind, e.val);
      end
    end
  endtask

  // Monitor: sample away from the rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.start_puf === 1'b1) got(c_EV_LAUNCH, 32'(bus.challenge));
      if (bus.key_valid === 1'b1 && bus.key_ready === 1'b1) got(c_EV_KEY, 32'(bus.key));
      if (bus.error === 1'b1 && prev_err === 1'b0) got(c_EV_ERR, 32'(bus.busy));
    end
    prev_err <= bus.error;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_gen(input logic [3:0] first, input logic [3:0] last);
    bus.gen_start  = 1'b1;
    bus.chal_first = first;
    bus.chal_last  = last;
    cyc();
    bus.gen_start  = 1'b0;
  endtask

  task automatic wait_start();
    int n = 0;
    while (bus.start_puf !== 1'b1 && n < 10) begin
      cyc();
      n++;
    end
    chk("start_puf_seen", 64'(bus.start_puf), 64'd1);
  endtask

  task automatic store(input logic [31:0] v, input logic with_done);
    bus.store_response_puf = 1'b1;
    bus.puf_response       = v;
    bus.puf_done           = with_done;
    cyc();
    bus.store_response_puf = 1'b0;
    bus.puf_done           = 1'b0;
  endtask

  task automatic done();
    bus.puf_done = 1'b1;
    cyc();
    bus.puf_done = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [31:0] t1 [8];
    logic [31:0] t6 [8];
    t1 = '{32'd10, 32'd5, 32'd7, 32'd9, 32'd2, 32'd1, 32'd8, 32'd8};
    t6 = '{32'd1, 32'd2, 32'd3, 32'd3, 32'd6, 32'd5, 32'd0, 32'd9};
    checks = 0;
    failures = 0;
    prev_err = 1'b0;
    reset = 1'b1;
    bus.gen_start = 1'b0;
    bus.chal_first = '0;
    bus.chal_last = '0;
    bus.key_ready = 1'b0;
    bus.puf_response = '0;
    bus.store_response_puf = 1'b0;
    bus.puf_done = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();

    // Reset state
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_key_valid", 64'(bus.key_valid), 64'd0);
    chk("rst_error", 64'(bus.error), 64'd0);
    chk("rst_start_puf", 64'(bus.start_puf), 64'd0);
    chk("rst_challenge", 64'(bus.challenge), 64'd0);
    chk("rst_key", 64'(bus.key), 64'd0);

    // T1: single challenge, full key inside one run, DRAIN waits for done
    push(c_EV_LAUNCH, 32'd3);
    push(c_EV_KEY, 32'h5);
    start_gen(4'd3, 4'd3);
    wait_start();
    chk("t1_challenge", 64'(bus.challenge), 64'd3);
    cyc();
    for (int i = 0; i < 8; i++) store(t1[i], 1'b0);
    chk("t1_drain_busy", 64'(bus.busy), 64'd1);
    for (int i = 0; i < 3; i++) cyc();
    chk("t1_drain_no_valid", 64'(bus.key_valid), 64'd0);
    done();
    chk("t1_key_valid", 64'(bus.key_valid), 64'd1);
    chk("t1_busy_low", 64'(bus.busy), 64'd0);
    chk("t1_key", 64'(bus.key), 64'h5);
    bus.key_ready = 1'b1;
    cyc();
    bus.key_ready = 1'b0;
    chk("t1_valid_dropped", 64'(bus.key_valid), 64'd0);
    chk("t1_key_kept", 64'(bus.key), 64'h5);

    // T2: one bit per run, odd sample dropped, range exhausted with 3 bits
    push(c_EV_LAUNCH, 32'd0);
    push(c_EV_LAUNCH, 32'd1);
    push(c_EV_LAUNCH, 32'd2);
    push(c_EV_ERR, 32'd0);
    start_gen(4'd0, 4'd2);
    for (int c = 0; c < 3; c++) begin
      wait_start();
      cyc();
      store(32'd9, 1'b0);
      store(32'd4, 1'b0);
      store(32'd1, 1'b0);
      done();
    end
    chk("t2_error", 64'(bus.error), 64'd1);
    chk("t2_busy", 64'(bus.busy), 64'd0);
    chk("t2_key_partial", 64'(bus.key), 64'h7);

    // T3: store and done together complete the key -> OUTPUT without DRAIN
    push(c_EV_LAUNCH, 32'd5);
    push(c_EV_LAUNCH, 32'd6);
    push(c_EV_KEY, 32'h9);
    start_gen(4'd5, 4'd6);
    chk("t3_error_cleared", 64'(bus.error), 64'd0);
    wait_start();
    cyc();
    store(32'd3, 1'b0);
    store(32'd1, 1'b0);
    store(32'd2, 1'b0);
    store(32'd5, 1'b0);
    done();
    wait_start();
    chk("t3_challenge6", 64'(bus.challenge), 64'd6);
    cyc();
    store(32'd7, 1'b0);
    store(32'd7, 1'b0);
    store(32'd9, 1'b0);
    store(32'd4, 1'b1);
    chk("t3_direct_output", 64'(bus.key_valid), 64'd1);
    chk("t3_key", 64'(bus.key), 64'h9);

    // T4: host stalls; key held stable and gen_start ignored
    bus.gen_start  = 1'b1;
    bus.chal_first = 4'd0;
    bus.chal_last  = 4'd0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("t4_hold_valid", 64'(bus.key_valid), 64'd1);
      chk("t4_hold_key", 64'(bus.key), 64'h9);
    end
    bus.gen_start = 1'b0;
    bus.key_ready = 1'b1;
    cyc();
    bus.key_ready = 1'b0;
    chk("t4_valid_dropped", 64'(bus.key_valid), 64'd0);

    // T5: inverted range faults without launch; timeout after 15 RUN cycles
    push(c_EV_ERR, 32'd0);
    start_gen(4'd7, 4'd2);
    chk("t5_bad_range_error", 64'(bus.error), 64'd1);
    chk("t5_bad_range_busy", 64'(bus.busy), 64'd0);
    cyc();
    push(c_EV_LAUNCH, 32'd1);
    push(c_EV_ERR, 32'd0);
    start_gen(4'd1, 4'd1);
    chk("t5_error_cleared", 64'(bus.error), 64'd0);
    wait_start();
    cyc();
    n = 0;
    while (bus.error !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    chk("t5_timeout_cycles", 64'(n), 64'd15);
    chk("t5_timeout_busy", 64'(bus.busy), 64'd0);

    // T6: asynchronous reset mid-RUN, then a clean run
    push(c_EV_LAUNCH, 32'd4);
    start_gen(4'd4, 4'd4);
    chk("t6_error_cleared", 64'(bus.error), 64'd0);
    wait_start();
    cyc();
    store(32'd10, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_busy", 64'(bus.busy), 64'd0);
    chk("t6_rst_start", 64'(bus.start_puf), 64'd0);
    chk("t6_rst_valid", 64'(bus.key_valid), 64'd0);
    chk("t6_rst_error", 64'(bus.error), 64'd0);
    chk("t6_rst_challenge", 64'(bus.challenge), 64'd0);
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    push(c_EV_LAUNCH, 32'd2);
    push(c_EV_KEY, 32'h4);
    start_gen(4'd2, 4'd2);
    wait_start();
    cyc();
    for (int i = 0; i < 8; i++) store(t6[i], 1'b0);
    done();
    chk("t6_key_valid", 64'(bus.key_valid), 64'd1);
    chk("t6_key", 64'(bus.key), 64'h4);
    bus.key_ready = 1'b1;
    cyc();
    bus.key_ready = 1'b0;
    cyc();
    cyc();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
